wfg_pat_drive: RTL and testbench

- Consumer end of the core synchronisation interface. Receives sync, subcycle, start, subcycle count and active from the waveform core.
- Produces CHANNELS registered pattern outputs. Each channel's mode is set by a 2-bit per-channel select and shaped by a subcycle window.
- Sits beside the core in the waveform generator. Configuration comes from a wishbone register block instantiated alongside it.

---
 rtl/wfg_pat_drive.sv | 206 ++++++++++++++++++++
 tb/tb_wfg_pat_drive.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_pat_drive.sv
// wfg_pat_drive: pattern driver on the consumer side of the waveform core
// synchronisation interface. It turns sync/subcycle timing into CHANNELS
// registered pattern bits. Each channel runs in one of four modes (0, 1,
// return-to-zero window, toggle). A shadow copy of the window and mode
// configuration is reloaded at every period boundary, so register writes
// made mid-period take effect from the next period.
//
// Handshake: there is no valid/ready flow control. Each input pulse
// (sync, subcycle, start) counts only on the rising clock edge where it
// is high. Every output is registered and reflects the state after that edge.
module wfg_pat_drive #(
  parameter int CHANNELS = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                ctrl_en_i,
  input  logic                wfg_pat_sync_i,
  input  logic                wfg_pat_subcycle_i,
  input  logic                wfg_pat_start_i,
  input  logic [7:0]          wfg_pat_subcycle_cnt_i,
  input  logic                active_i,
  input  logic [7:0]          cfg_begin_i,
  input  logic [7:0]          cfg_end_i,
  input  logic [CHANNELS-1:0] patsel0_i,
  input  logic [CHANNELS-1:0] patsel1_i,
  output logic [CHANNELS-1:0] pat_o,
  output logic [15:0]         period_cnt_o,
  output logic                restart_err_o,
  output logic                active_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Control strobes decoded by the FSM for the current cycle
  logic arm_cyc;    // IDLE -> ARMED transition
  logic start_cyc;  // ARMED -> RUN transition (the start cycle)
  logic run_eval;   // cycle evaluated as a RUN cycle (start cycle or staying in RUN)
  logic load_cfg;   // shadow config reloads this cycle

  // Shadow configuration
  logic [7:0]          begin_q, begin_d;
  logic [7:0]          end_q, end_d;
  logic [CHANNELS-1:0] sel0_q, sel0_d;
  logic [CHANNELS-1:0] sel1_q, sel1_d;

  // Configuration in effect for this cycle's evaluation
  logic [7:0]          begin_eff;
  logic [7:0]          end_eff;
  logic [CHANNELS-1:0] sel0_eff;
  logic [CHANNELS-1:0] sel1_eff;

  // Pattern datapath
  logic                in_win;
  logic                begin_hit;
  logic [CHANNELS-1:0] tog_q, tog_d;
  logic [CHANNELS-1:0] tog_base;
  logic [CHANNELS-1:0] tog_eval;
  logic [CHANNELS-1:0] pat_eval;
  logic [CHANNELS-1:0] pat_q, pat_d;

  // Status registers
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        active_q, active_d;

  // Next-state logic. A disable or loss of active is checked before any
  // pattern activity, so it wins over a same-cycle subcycle pulse.
  always_comb begin
    state_d   = state_q;
    arm_cyc   = 1'b0;
    start_cyc = 1'b0;
    run_eval  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_i) begin
          state_d = ST_ARMED;
          arm_cyc = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!ctrl_en_i) begin
          state_d = ST_IDLE;
        end else if (wfg_pat_start_i && active_i) begin
          state_d   = ST_RUN;
          start_cyc = 1'b1;
          run_eval  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ctrl_en_i || !active_i) begin
          state_d = ST_IDLE;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Effective configuration: a loading cycle uses the incoming values directly
  always_comb begin
    load_cfg  = start_cyc | (run_eval & wfg_pat_sync_i);
    begin_eff = load_cfg ? cfg_begin_i : begin_q;
    end_eff   = load_cfg ? cfg_end_i   : end_q;
    sel0_eff  = load_cfg ? patsel0_i   : sel0_q;
    sel1_eff  = load_cfg ? patsel1_i   : sel1_q;
    begin_d   = begin_eff;
    end_d     = end_eff;
    sel0_d    = sel0_eff;
    sel1_d    = sel1_eff;
  end

  // Window test, including the wrap-around case where begin > end
  always_comb begin
    in_win = 1'b0;
    if (begin_eff <= end_eff) begin
      in_win = (wfg_pat_subcycle_cnt_i >= begin_eff) &&
               (wfg_pat_subcycle_cnt_i <= end_eff);
    end else begin
      in_win = (wfg_pat_subcycle_cnt_i >= begin_eff) ||
               (wfg_pat_subcycle_cnt_i <= end_eff);
    end
    begin_hit = (wfg_pat_subcycle_cnt_i == begin_eff);
  end

  // Per-channel mode decode and toggle tracking
  always_comb begin
    tog_base = start_cyc ? '0 : tog_q;
    tog_eval = begin_hit ? ~tog_base : tog_base;
    pat_eval = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({sel1_eff[i], sel0_eff[i]})
        2'b00:   pat_eval[i] = 1'b0;
        2'b01:   pat_eval[i] = 1'b1;
        2'b10:   pat_eval[i] = in_win;
        default: pat_eval[i] = tog_eval[i];
      endcase
    end
  end

  // Output/status next values; pattern updates only on subcycle pulses in RUN
  always_comb begin
    pat_d    = '0;
    tog_d    = tog_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    active_d = (state_d == ST_RUN);
    if (run_eval) begin
      pat_d = wfg_pat_subcycle_i ? pat_eval : pat_q;
      if (wfg_pat_subcycle_i) begin
        tog_d = tog_eval;
      end else if (start_cyc) begin
        tog_d = '0;
      end
    end
    if (start_cyc) begin
      cnt_d = 16'd1;
    end else if (run_eval && wfg_pat_sync_i) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (arm_cyc) begin
      err_d = 1'b0;
    end else if ((state_q == ST_RUN) && wfg_pat_start_i) begin
      err_d = 1'b1;
    end
  end

  // State, shadow config and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      begin_q  <= '0;
      end_q    <= '0;
      sel0_q   <= '0;
      sel1_q   <= '0;
      tog_q    <= '0;
      pat_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      begin_q  <= begin_d;
      end_q    <= end_d;
      sel0_q   <= sel0_d;
      sel1_q   <= sel1_d;
      tog_q    <= tog_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign pat_o         = pat_q;
  assign period_cnt_o  = cnt_q;
  assign restart_err_o = err_q;
  assign active_o      = active_q;

endmodule

// File: tb/tb_wfg_pat_drive.sv
// Testbench for wfg_pat_drive: table-driven vectors for the basic window
// modes, then hand-written sequences for toggle, shadow config, disable,
// restart error, counter wrap and reset.
module tb_wfg_pat_drive;

  localparam int CH = 32;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sync;
  logic          sub;
  logic          start;
  logic [7:0]    cnt;
  logic          act_in;
  logic [7:0]    cfg_b;
  logic [7:0]    cfg_e;
  logic [CH-1:0] sel0;
  logic [CH-1:0] sel1;
  logic [CH-1:0] pat;
  logic [15:0]   pcnt;
  logic          err;
  logic          act_out;

  int checks = 0;
  int errors = 0;
  logic [CH-1:0] exp_q[$];

  wfg_pat_drive #(.CHANNELS(CH)) dut (
    .wb_clk_i               (clk),
    .wb_rst_i               (rst),
    .ctrl_en_i              (en),
    .wfg_pat_sync_i         (sync),
    .wfg_pat_subcycle_i     (sub),
    .wfg_pat_start_i        (start),
    .wfg_pat_subcycle_cnt_i (cnt),
    .active_i               (act_in),
    .cfg_begin_i            (cfg_b),
    .cfg_end_i              (cfg_e),
    .patsel0_i              (sel0),
    .patsel1_i              (sel1),
    .pat_o                  (pat),
    .period_cnt_o           (pcnt),
    .restart_err_o          (err),
    .active_o               (act_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en, act, st, sy, sb;
    logic [7:0]    c, b, e;
    logic [CH-1:0] s0, s1;
    logic [CH-1:0] exp_pat;
    logic [15:0]   exp_cnt;
    logic          exp_act, exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic v_en, input logic v_act, input logic v_st,
                               input logic v_sy, input logic v_sb, input logic [7:0] v_c,
                               input logic [7:0] v_b, input logic [7:0] v_e,
                               input logic [CH-1:0] v_s0, input logic [CH-1:0] v_s1,
                               input logic [CH-1:0] v_pat, input logic [15:0] v_cnt,
                               input logic v_xact, input logic v_xerr);
    vec_t v;
    v.en = v_en; v.act = v_act; v.st = v_st; v.sy = v_sy; v.sb = v_sb;
    v.c = v_c; v.b = v_b; v.e = v_e; v.s0 = v_s0; v.s1 = v_s1;
    v.exp_pat = v_pat; v.exp_cnt = v_cnt; v.exp_act = v_xact; v.exp_err = v_xerr;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d_en, input logic d_act, input logic d_st,
                       input logic d_sy, input logic d_sb, input logic [7:0] d_c);
    en = d_en; act_in = d_act; start = d_st; sync = d_sy; sub = d_sb; cnt = d_c;
  endtask

  task automatic set_cfg(input logic [7:0] b, input logic [7:0] e,
                         input logic [CH-1:0] s0, input logic [CH-1:0] s1);
    cfg_b = b; cfg_e = e; sel0 = s0; sel1 = s1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input logic [CH-1:0] e_pat,
                         input logic [15:0] e_cnt, input logic e_act, input logic e_err);
    chk({tag, " pat"}, 32'(pat), 32'(e_pat));
    chk({tag, " period_cnt"}, 32'(pcnt), 32'(e_cnt));
    chk({tag, " active"}, 32'(act_out), 32'(e_act));
    chk({tag, " restart_err"}, 32'(err), 32'(e_err));
  endtask

  initial begin
    logic [CH-1:0] want;
    logic          tog;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 8'd0);
    set_cfg(8'd0, 8'd0, '0, '0);

    // ---------------- vector table: RZ window, wrap, sync-only, single subcycle
    // arm, then start+sync+sub at cnt 0 with window 2..4 on ch0
    vecs.push_back(mkv(1,0,0,0,0, 8'd0, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd0, 0, 0));
    vecs.push_back(mkv(1,1,1,1,1, 8'd0, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd1, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd2, 8'd2, 8'd4, 32'h0, 32'h1, 32'h1, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd3, 8'd2, 8'd4, 32'h0, 32'h1, 32'h1, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd4, 8'd2, 8'd4, 32'h0, 32'h1, 32'h1, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd5, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd6, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd1, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd7, 8'd2, 8'd4, 32'h0, 32'h1, 32'h0, 16'd1, 1, 0));
    // wrap window 6..1 loaded on the next sync
    vecs.push_back(mkv(1,1,0,1,1, 8'd0, 8'd6, 8'd1, 32'h0, 32'h1, 32'h1, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd1, 8'd6, 8'd1, 32'h0, 32'h1, 32'h1, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd2, 8'd6, 8'd1, 32'h0, 32'h1, 32'h0, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd3, 8'd6, 8'd1, 32'h0, 32'h1, 32'h0, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd4, 8'd6, 8'd1, 32'h0, 32'h1, 32'h0, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd5, 8'd6, 8'd1, 32'h0, 32'h1, 32'h0, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd6, 8'd6, 8'd1, 32'h0, 32'h1, 32'h1, 16'd2, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd7, 8'd6, 8'd1, 32'h0, 32'h1, 32'h1, 16'd2, 1, 0));
    // sync without subcycle: counter moves, pat holds
    vecs.push_back(mkv(1,1,0,1,0, 8'd0, 8'd6, 8'd1, 32'h0, 32'h1, 32'h1, 16'd3, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd2, 8'd6, 8'd1, 32'h0, 32'h1, 32'h0, 16'd3, 1, 0));
    // single-subcycle window 3..3
    vecs.push_back(mkv(1,1,0,1,1, 8'd3, 8'd3, 8'd3, 32'h0, 32'h1, 32'h1, 16'd4, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd4, 8'd3, 8'd3, 32'h0, 32'h1, 32'h0, 16'd4, 1, 0));
    vecs.push_back(mkv(1,1,0,0,1, 8'd2, 8'd3, 8'd3, 32'h0, 32'h1, 32'h0, 16'd4, 1, 0));

    do_reset();
    chk_all("reset", '0, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].act, vecs[i].st, vecs[i].sy, vecs[i].sb, vecs[i].c);
      set_cfg(vecs[i].b, vecs[i].e, vecs[i].s0, vecs[i].s1);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pat, vecs[i].exp_cnt,
              vecs[i].exp_act, vecs[i].exp_err);
    end

    // ---------------- toggle on ch1 (begin=3), constant 1 on ch0, 3 periods
    do_reset();
    set_cfg(8'd3, 8'd7, 32'h3, 32'h2);
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    tog = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 3) tog = ~tog;
        want = '0;
        want[0] = 1'b1;
        want[1] = tog;
        exp_q.push_back(want);
      end
    end
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) begin
        drive(1, 1, (p == 0 && c == 0), (c == 0), 1, 8'(c));
        tick();
        want = exp_q.pop_front();
        chk($sformatf("toggle p%0d c%0d pat", p, c), 32'(pat), 32'(want));
      end
      chk($sformatf("toggle p%0d period_cnt", p), 32'(pcnt), p + 1);
    end

    // ---------------- begin changes mid-period: 2..6 now, 5..6 next period
    do_reset();
    set_cfg(8'd2, 8'd6, 32'h0, 32'h1);
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 8; c++) begin
        if (p == 0 && c == 2) cfg_b = 8'd5;
        drive(1, 1, (p == 0 && c == 0), (c == 0), 1, 8'(c));
        tick();
        want = '0;
        want[0] = (p == 0) ? (c >= 2 && c <= 6) : (c >= 5 && c <= 6);
        chk($sformatf("shadow p%0d c%0d pat", p, c), 32'(pat), 32'(want));
      end
    end

    // ---------------- restart error, active drop with same-cycle subcycle
    do_reset();
    set_cfg(8'd0, 8'd7, 32'h0, 32'h1);
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    drive(1, 1, 1, 1, 1, 8'd0);
    tick();
    chk_all("run start", 32'h1, 16'd1, 1'b1, 1'b0);
    drive(1, 1, 1, 0, 1, 8'd1);
    tick();
    chk_all("restart in run", 32'h1, 16'd1, 1'b1, 1'b1);
    drive(1, 1, 0, 0, 1, 8'd2);
    tick();
    chk_all("err sticky", 32'h1, 16'd1, 1'b1, 1'b1);
    drive(1, 0, 0, 1, 1, 8'd3);
    tick();
    chk_all("active drop", 32'h0, 16'd1, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0, 8'd4);
    tick();
    chk_all("en low idle", 32'h0, 16'd1, 1'b0, 1'b1);
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    chk_all("rearm clears err", 32'h0, 16'd1, 1'b0, 1'b0);
    drive(0, 1, 1, 1, 1, 8'd0);
    tick();
    chk_all("armed disable", 32'h0, 16'd1, 1'b0, 1'b0);

    // ---------------- period counter wrap, then reset mid-run
    do_reset();
    set_cfg(8'd0, 8'd7, 32'h1, 32'h0);
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    drive(1, 1, 1, 1, 1, 8'd0);
    tick();
    chk_all("wrap start", 32'h1, 16'd1, 1'b1, 1'b0);
    drive(1, 1, 0, 1, 0, 8'd0);
    for (int k = 0; k < 65534; k++) tick();
    chk_all("cnt at ffff", 32'h1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    chk_all("cnt wrapped", 32'h1, 16'h0000, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("reset mid-run", 32'h0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1, 1, 1, 1, 1, 8'd0);
    tick();
    chk("after reset idle->armed active", 32'(act_out), 32'd0);
    tick();
    chk("after reset armed->run active", 32'(act_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
